// File: rtl/pulse_gap_meter.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_gap_meter
//  Purpose  : Measures high-run (pulse) and following low-run (gap) lengths of
//             a serial stream, reports each complete period and flags lock
//             once the same non-saturated period repeats LOCK_COUNT times.
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_gap_meter #(
    parameter int CNT_W      = 5,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             serial_in,
    output logic [CNT_W-1:0] pulse_len,
    output logic [CNT_W-1:0] gap_len,
    output logic [CNT_W:0]   period_len,
    output logic             meas_valid,
    output logic             meas_sat,
    output logic             locked
);

    localparam logic [1:0]       S_SYNC = 2'd0;
    localparam logic [1:0]       S_HIGH = 2'd1;
    localparam logic [1:0]       S_LOW  = 2'd2;

    localparam logic [CNT_W-1:0] C_MAX  = '1;
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       C_LOCK = 4'(LOCK_COUNT);

    logic [1:0]       r_state;
    logic             r_prev;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_lcnt;
    logic [CNT_W-1:0] r_hold;
    logic             r_hsat;
    logic             r_prev_ok;   // previous report was non-saturated
    logic [3:0]       r_match;

    logic [CNT_W-1:0] w_hcnt_inc;
    logic [CNT_W-1:0] w_lcnt_inc;
    logic             w_period_sat;
    logic             w_same;
    logic [3:0]       w_match_next;

    // Saturating increments and the lock-counter update for a completed period
    always_comb begin
        w_hcnt_inc   = (r_hcnt == C_MAX) ? C_MAX : r_hcnt + 1'b1;
        w_lcnt_inc   = (r_lcnt == C_MAX) ? C_MAX : r_lcnt + 1'b1;
        w_period_sat = r_hsat | (r_lcnt == C_MAX);
        w_same       = r_prev_ok && (r_hold == pulse_len) && (r_lcnt == gap_len);
        w_match_next = 4'd1;
        if (w_period_sat) begin
            w_match_next = 4'd0;
        end else if (w_same) begin
            w_match_next = (r_match >= C_LOCK) ? C_LOCK : r_match + 1'b1;
        end
    end

    // Run-length state machine, report registers and lock tracking
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_SYNC;
            r_prev     <= 1'b1;
            r_hcnt     <= '0;
            r_lcnt     <= '0;
            r_hold     <= '0;
            r_hsat     <= 1'b0;
            r_prev_ok  <= 1'b0;
            r_match    <= 4'd0;
            pulse_len  <= '0;
            gap_len    <= '0;
            period_len <= '0;
            meas_valid <= 1'b0;
            meas_sat   <= 1'b0;
            locked     <= 1'b0;
        end else if (clear) begin
            r_state    <= S_SYNC;
            r_prev     <= 1'b1;
            r_hcnt     <= '0;
            r_lcnt     <= '0;
            r_hold     <= '0;
            r_hsat     <= 1'b0;
            r_prev_ok  <= 1'b0;
            r_match    <= 4'd0;
            pulse_len  <= '0;
            gap_len    <= '0;
            period_len <= '0;
            meas_valid <= 1'b0;
            meas_sat   <= 1'b0;
            locked     <= 1'b0;
        end else begin
            r_prev     <= serial_in;
            meas_valid <= 1'b0;
            case (r_state)
                S_SYNC: begin
                    // Only a genuine 0->1 edge starts measurement
                    if (!r_prev && serial_in) begin
                        r_hcnt  <= C_ONE;
                        r_state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (serial_in) begin
                        r_hcnt <= w_hcnt_inc;
                        // A stuck-high stream cannot stay locked
                        if (w_hcnt_inc == C_MAX) begin
                            r_match <= 4'd0;
                            locked  <= 1'b0;
                        end
                    end else begin
                        r_hold  <= r_hcnt;
                        r_hsat  <= (r_hcnt == C_MAX);
                        r_lcnt  <= C_ONE;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (!serial_in) begin
                        r_lcnt <= w_lcnt_inc;
                        // A stuck-low stream cannot stay locked
                        if (w_lcnt_inc == C_MAX) begin
                            r_match <= 4'd0;
                            locked  <= 1'b0;
                        end
                    end else begin
                        pulse_len  <= r_hold;
                        gap_len    <= r_lcnt;
                        period_len <= {1'b0, r_hold} + {1'b0, r_lcnt};
                        meas_valid <= 1'b1;
                        meas_sat   <= w_period_sat;
                        r_prev_ok  <= ~w_period_sat;
                        r_match    <= w_match_next;
                        locked     <= (w_match_next == C_LOCK);
                        r_hcnt     <= C_ONE;
                        r_state    <= S_HIGH;
                    end
                end
                default: begin
                    r_state <= S_SYNC;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_gap_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_gap_meter
//  Purpose  : Directed self-checking bench for pulse_gap_meter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_gap_meter;

    logic       clock;
    logic       reset_n;
    logic       clear;
    logic       serial_in;
    logic [4:0] pulse_len;
    logic [4:0] gap_len;
    logic [5:0] period_len;
    logic       meas_valid;
    logic       meas_sat;
    logic       locked;

    int n_cmp;
    int n_bad;

    // Report log, filled by send_bit whenever meas_valid is seen
    logic [7:0] ev_p   [16];
    logic [7:0] ev_g   [16];
    logic [7:0] ev_per [16];
    logic       ev_s   [16];
    logic       ev_l   [16];
    int         ev_bit [16];
    int         ev_n;
    int         bitno;
    int         fall_bit;
    logic       prev_locked;

    pulse_gap_meter #(.CNT_W(5), .LOCK_COUNT(3)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .serial_in  (serial_in),
        .pulse_len  (pulse_len),
        .gap_len    (gap_len),
        .period_len (period_len),
        .meas_valid (meas_valid),
        .meas_sat   (meas_sat),
        .locked     (locked)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_events();
        for (int i = 0; i < 16; i++) begin
            ev_p[i] = '1; ev_g[i] = '1; ev_per[i] = '1;
            ev_s[i] = 1'bx; ev_l[i] = 1'bx; ev_bit[i] = -1;
        end
        ev_n        = 0;
        bitno       = 0;
        fall_bit    = -1;
        prev_locked = locked;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clock);
        #1;
        if (meas_valid === 1'b1 && ev_n < 16) begin
            ev_p[ev_n]   = 8'(pulse_len);
            ev_g[ev_n]   = 8'(gap_len);
            ev_per[ev_n] = 8'(period_len);
            ev_s[ev_n]   = meas_sat;
            ev_l[ev_n]   = locked;
            ev_bit[ev_n] = bitno;
            ev_n++;
        end
        if (prev_locked === 1'b1 && locked === 1'b0 && fall_bit < 0) fall_bit = bitno;
        prev_locked = locked;
        bitno++;
    endtask

    task automatic send_pattern(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) send_bit(1'b1);
            for (int i = 0; i < lo; i++) send_bit(1'b0);
        end
    endtask

    task automatic do_reset(input logic din);
        serial_in = din;
        clear     = 1'b0;
        reset_n   = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        clear_events();
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        n_cmp++;
        if ({pulse_len, gap_len, period_len, meas_valid, meas_sat, locked} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_state: got p=%0d g=%0d per=%0d v=%0d s=%0d l=%0d, expected all 0",
                     pulse_len, gap_len, period_len, meas_valid, meas_sat, locked);
        end
    endtask

    // 11-high/5-low stream: first report after one discarded partial period
    task automatic test_pattern_11_5();
        int ex [0:3][0:5];
        ex = '{'{32, 11, 5, 16, 0, 0}, '{48, 11, 5, 16, 0, 0},
               '{64, 11, 5, 16, 0, 1}, '{80, 11, 5, 16, 0, 1}};
        do_reset(1'b0);
        send_pattern(11, 5, 6);
        n_cmp++;
        if (ev_n !== 4) begin
            n_bad++;
            $display("FAIL p11_5_count: got %0d reports, expected 4", ev_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ev_bit[i] !== ex[i][0] || ev_p[i] !== 8'(ex[i][1]) || ev_g[i] !== 8'(ex[i][2]) ||
                ev_per[i] !== 8'(ex[i][3]) || ev_s[i] !== 1'(ex[i][4]) || ev_l[i] !== 1'(ex[i][5])) begin
                n_bad++;
                $display("FAIL p11_5 ev%0d: got bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d, expected bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d",
                         i, ev_bit[i], ev_p[i], ev_g[i], ev_per[i], ev_s[i], ev_l[i],
                         ex[i][0], ex[i][1], ex[i][2], ex[i][3], ex[i][4], ex[i][5]);
            end
        end
    endtask

    // Continue from lock on 11/5, switch to 8/8
    task automatic test_pattern_switch();
        int ex [0:3][0:5];
        ex = '{'{0, 11, 5, 16, 0, 1}, '{16, 8, 8, 16, 0, 0},
               '{32, 8, 8, 16, 0, 0}, '{48, 8, 8, 16, 0, 1}};
        clear_events();
        send_pattern(8, 8, 4);
        n_cmp++;
        if (ev_n !== 4) begin
            n_bad++;
            $display("FAIL switch_count: got %0d reports, expected 4", ev_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ev_bit[i] !== ex[i][0] || ev_p[i] !== 8'(ex[i][1]) || ev_g[i] !== 8'(ex[i][2]) ||
                ev_per[i] !== 8'(ex[i][3]) || ev_s[i] !== 1'(ex[i][4]) || ev_l[i] !== 1'(ex[i][5])) begin
                n_bad++;
                $display("FAIL switch ev%0d: got bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d, expected bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d",
                         i, ev_bit[i], ev_p[i], ev_g[i], ev_per[i], ev_s[i], ev_l[i],
                         ex[i][0], ex[i][1], ex[i][2], ex[i][3], ex[i][4], ex[i][5]);
            end
        end
    endtask

    // Fastest possible stream 1,0,1,0
    task automatic test_alternating();
        int ex [0:3][0:5];
        ex = '{'{4, 1, 1, 2, 0, 0}, '{6, 1, 1, 2, 0, 0},
               '{8, 1, 1, 2, 0, 1}, '{10, 1, 1, 2, 0, 1}};
        do_reset(1'b0);
        send_pattern(1, 1, 6);
        n_cmp++;
        if (ev_n !== 4) begin
            n_bad++;
            $display("FAIL alt_count: got %0d reports, expected 4", ev_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ev_bit[i] !== ex[i][0] || ev_p[i] !== 8'(ex[i][1]) || ev_g[i] !== 8'(ex[i][2]) ||
                ev_per[i] !== 8'(ex[i][3]) || ev_s[i] !== 1'(ex[i][4]) || ev_l[i] !== 1'(ex[i][5])) begin
                n_bad++;
                $display("FAIL alt ev%0d: got bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d, expected bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d",
                         i, ev_bit[i], ev_p[i], ev_g[i], ev_per[i], ev_s[i], ev_l[i],
                         ex[i][0], ex[i][1], ex[i][2], ex[i][3], ex[i][4], ex[i][5]);
            end
        end
    endtask

    // Stuck high while locked: lock drops when hcnt hits 31
    task automatic test_stall();
        int ex [0:1][0:5];
        ex = '{'{0, 1, 1, 2, 0, 1}, '{45, 31, 5, 36, 1, 0}};
        clear_events();
        send_pattern(40, 5, 1);
        send_bit(1'b1);
        n_cmp++;
        if (fall_bit !== 30) begin
            n_bad++;
            $display("FAIL stall_lock_drop: got drop at bit %0d, expected bit 30", fall_bit);
        end
        n_cmp++;
        if (ev_n !== 2) begin
            n_bad++;
            $display("FAIL stall_count: got %0d reports, expected 2", ev_n);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ev_bit[i] !== ex[i][0] || ev_p[i] !== 8'(ex[i][1]) || ev_g[i] !== 8'(ex[i][2]) ||
                ev_per[i] !== 8'(ex[i][3]) || ev_s[i] !== 1'(ex[i][4]) || ev_l[i] !== 1'(ex[i][5])) begin
                n_bad++;
                $display("FAIL stall ev%0d: got bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d, expected bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d",
                         i, ev_bit[i], ev_p[i], ev_g[i], ev_per[i], ev_s[i], ev_l[i],
                         ex[i][0], ex[i][1], ex[i][2], ex[i][3], ex[i][4], ex[i][5]);
            end
        end
    endtask

    // High at reset release: the initial long high run is discarded
    task automatic test_initial_high();
        int ex [0:1][0:5];
        ex = '{'{39, 11, 5, 16, 0, 0}, '{55, 11, 5, 16, 0, 0}};
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        send_pattern(11, 5, 3);
        send_bit(1'b1);
        n_cmp++;
        if (ev_n !== 2) begin
            n_bad++;
            $display("FAIL init_high_count: got %0d reports, expected 2", ev_n);
        end
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ev_bit[i] !== ex[i][0] || ev_p[i] !== 8'(ex[i][1]) || ev_g[i] !== 8'(ex[i][2]) ||
                ev_per[i] !== 8'(ex[i][3]) || ev_s[i] !== 1'(ex[i][4]) || ev_l[i] !== 1'(ex[i][5])) begin
                n_bad++;
                $display("FAIL init_high ev%0d: got bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d, expected bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d",
                         i, ev_bit[i], ev_p[i], ev_g[i], ev_per[i], ev_s[i], ev_l[i],
                         ex[i][0], ex[i][1], ex[i][2], ex[i][3], ex[i][4], ex[i][5]);
            end
        end
    endtask

    // Async reset mid-HIGH while locked, then synchronous clear while locked
    task automatic test_reset_and_clear();
        int ex [0:2][0:5];
        ex = '{'{32, 11, 5, 16, 0, 0}, '{48, 11, 5, 16, 0, 0}, '{64, 11, 5, 16, 0, 1}};
        do_reset(1'b0);
        send_pattern(11, 5, 5);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_reset_lock: got locked=%0d, expected 1", locked);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({pulse_len, gap_len, period_len, meas_valid, meas_sat, locked} !== 19'd0) begin
            n_bad++;
            $display("FAIL async_reset: got p=%0d g=%0d per=%0d v=%0d s=%0d l=%0d, expected all 0",
                     pulse_len, gap_len, period_len, meas_valid, meas_sat, locked);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            clear_events();
            send_pattern(11, 5, 4);
            send_bit(1'b1);
            n_cmp++;
            if (ev_n !== 3) begin
                n_bad++;
                $display("FAIL relock%0d_count: got %0d reports, expected 3", pass, ev_n);
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (ev_bit[i] !== ex[i][0] || ev_p[i] !== 8'(ex[i][1]) || ev_g[i] !== 8'(ex[i][2]) ||
                    ev_per[i] !== 8'(ex[i][3]) || ev_s[i] !== 1'(ex[i][4]) || ev_l[i] !== 1'(ex[i][5])) begin
                    n_bad++;
                    $display("FAIL relock%0d ev%0d: got bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d, expected bit=%0d p=%0d g=%0d per=%0d sat=%0d lock=%0d",
                             pass, i, ev_bit[i], ev_p[i], ev_g[i], ev_per[i], ev_s[i], ev_l[i],
                             ex[i][0], ex[i][1], ex[i][2], ex[i][3], ex[i][4], ex[i][5]);
                end
            end
            if (pass == 0) begin
                clear = 1'b1;
                send_bit(1'b1);
                clear = 1'b0;
                n_cmp++;
                if ({pulse_len, gap_len, period_len, meas_valid, meas_sat, locked} !== 19'd0) begin
                    n_bad++;
                    $display("FAIL sync_clear: got p=%0d g=%0d per=%0d v=%0d s=%0d l=%0d, expected all 0",
                             pulse_len, gap_len, period_len, meas_valid, meas_sat, locked);
                end
            end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        clear     = 1'b0;
        serial_in = 1'b0;
        test_reset();
        test_pattern_11_5();
        test_pattern_switch();
        test_alternating();
        test_stall();
        test_initial_high();
        test_reset_and_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_gap_meter.md
Name: pulse_gap_meter

Overview:
Downstream consumer of the 16-bit circular shift register's serial `shift_out` stream. It measures each high run (pulse) and the low run that follows (gap) in clock cycles. It reports every complete pulse/gap period and asserts `locked` once the pattern repeats identically. Typical use: confirm that a loaded 11-over-5 word produces a stable 11-high/5-low waveform.

Parameters:
- CNT_W, 5, width of the run-length counters; a run saturates at 2^CNT_W-1.
- LOCK_COUNT, 3, number of consecutive identical non-saturated periods needed to assert `locked` (valid range 1 to 15).

Ports:
- clock, input, 1, rising-edge clock shared with the shift register.
- reset_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous restart; same effect as reset, but applied at the clock edge.
- serial_in, input, 1, serial stream (the shift register's `shift_out`), sampled every rising edge.
- pulse_len, output, CNT_W, length of the last completed high run.
- gap_len, output, CNT_W, length of the last completed low run.
- period_len, output, CNT_W+1, pulse_len + gap_len with no truncation.
- meas_valid, output, 1, one-cycle strobe when the three length outputs update.
- meas_sat, output, 1, qualifies meas_valid: pulse or gap counter saturated in that period.
- locked, output, 1, the stream is periodic and stable.

Behaviour:
- Reset/clear values:
  - outputs: pulse_len, gap_len and period_len = 0; meas_valid, meas_sat and locked = 0.
  - internal: state = SYNC, prev = 1, match_cnt = 0.
  - `clear` has priority over all other activity in its cycle.
- Sampling: d = serial_in at each rising edge; prev = d from the previous edge. A rise is prev=0 and d=1. prev resetting to 1 guarantees the partial run present at reset is discarded.
- SYNC: wait for a rise. On a rise, go to HIGH with hcnt=1. No other action.
- HIGH:
  - d=1: hcnt saturating-increments.
  - d=0: hold = hcnt, hsat = (hcnt saturated), lcnt = 1, go to LOW.
- LOW:
  - d=0: lcnt saturating-increments.
  - d=1 (period complete):
    - pulse_len = hold, gap_len = lcnt, period_len = hold + lcnt.
    - meas_sat = hsat OR (lcnt saturated).
    - meas_valid = 1 for exactly one cycle.
    - hcnt = 1, go to HIGH.
- Latency: meas_valid and the new lengths are visible in the cycle after the edge that sampled the first 1 of the next pulse. Lengths stay held until the next meas_valid.
- Saturation: a counter at 2^CNT_W-1 holds that value.
- Lock logic (updated on the same edge as meas_valid):
  - Saturated period: match_cnt = 0.
  - Non-saturated period that equals the previous reported (pulse, gap) and the previous was also non-saturated: match_cnt increments, saturating at LOCK_COUNT.
  - Any other non-saturated period: match_cnt = 1.
  - locked = (match_cnt == LOCK_COUNT), registered, so it changes in the same cycle as meas_valid.
- Stall detect: if hcnt or lcnt reaches saturation while running, locked and match_cnt clear on that same edge, without waiting for the period to complete.
- Reset mid-run: the in-progress period is lost. After release, re-sync requires a 0 followed by a 1. A constant-high input after reset never leaves SYNC.
- period_len is CNT_W+1 bits wide, so it cannot overflow (max 2*(2^CNT_W-1)).

Test Plan:
- Stream 1111111111100000 repeating (circular register loaded, shifting) → first meas_valid gives pulse_len=11, gap_len=5, period_len=16, meas_sat=0. meas_valid then repeats every 16 cycles. locked=1 coincides with the 3rd meas_valid.
- Locked on 11/5, then pattern switched to 8 high/8 low → the first 8/8 meas_valid shows locked=0 (match_cnt=1). locked=1 returns on the 3rd consecutive 8/8 period.
- Alternating 1,0,1,0 → every meas_valid reports 1/1/2. locked after 3 periods.
- While locked, serial_in held at 1 for 40 cycles, then 0 for 5, then 1 → locked drops on the edge where hcnt reaches 31. The next meas_valid reports pulse_len=31, gap_len=5, meas_sat=1, locked=0.
- serial_in = 1 at reset release for 7 cycles, then the 11/5 pattern → the initial 7-cycle run is never reported. The first report is 11/5.
- reset_n low mid-HIGH while locked, and separately clear=1 for one cycle → all outputs return to 0 immediately (async) or at the next edge (clear). Re-lock needs 3 full periods.
